// File: rtl/boreal_kin_pkg.sv
// Shared kinematics constants and helpers for the boreal CORDIC FK/IK engines.
// Angles are signed Q2.13 radians carried in Z_W bits; positions are Q.8 in XY_W bits.
package boreal_kin_pkg;

  localparam int THETA_W  = 16;
  localparam int POS_W    = 16;
  localparam int Z_W      = 18;
  localparam int XY_W     = 24;
  localparam int FRAC_W   = 8;
  localparam int SUM_W    = XY_W + 1;
  localparam int ITERS    = 16;
  localparam int ITER_W   = 4;
  localparam int KINV_Q16 = 39797;
  localparam int L1_DEF   = 100;
  localparam int L2_DEF   = 100;

  typedef logic signed [Z_W-1:0]   z_t;
  typedef logic signed [XY_W-1:0]  xy_t;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic signed [POS_W-1:0] pos_t;

  localparam z_t PI      = 18'sd25736;
  localparam z_t HALF_PI = 18'sd12868;
  localparam z_t TWO_PI  = 18'sd51472;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ITER1,
    ST_LOAD2,
    ST_ITER2,
    ST_SUM,
    ST_HOLD
  } fk_state_e;

  // atan(2^-i) in Q2.13; the last entry has rounded to zero.
  function automatic z_t atan_lut(input logic [ITER_W-1:0] i);
    case (i)
      4'd0:    return 18'sd6434;
      4'd1:    return 18'sd3798;
      4'd2:    return 18'sd2007;
      4'd3:    return 18'sd1019;
      4'd4:    return 18'sd511;
      4'd5:    return 18'sd256;
      4'd6:    return 18'sd128;
      4'd7:    return 18'sd64;
      4'd8:    return 18'sd32;
      4'd9:    return 18'sd16;
      4'd10:   return 18'sd8;
      4'd11:   return 18'sd4;
      4'd12:   return 18'sd2;
      4'd13:   return 18'sd1;
      4'd14:   return 18'sd1;
      default: return '0;
    endcase
  endfunction

  // Link length pre-scaled by 1/K so the rotated vector comes out at true length in Q.8.
  function automatic xy_t start_mag(input int len);
    return xy_t'((len * KINV_Q16) >>> FRAC_W);
  endfunction

  function automatic pos_t sat_pos(input sum_t v);
    if (v > sum_t'(32767))       return 16'sh7fff;
    else if (v < sum_t'(-32768)) return 16'sh8000;
    else                         return v[POS_W-1:0];
  endfunction

endpackage

// File: rtl/boreal_cordic_rotate.sv
// Iterative rotation-mode CORDIC core: load (x0, 0, z0), then 16 shift/add
// micro-rotations on consecutive cycles; last flags the final iteration.
module boreal_cordic_rotate
  import boreal_kin_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  xy_t  x0,
  input  z_t   z0,
  output xy_t  x,
  output xy_t  y,
  output logic last
);

  logic              busy;
  logic [ITER_W-1:0] iter;
  z_t                z;
  xy_t               x_sh;
  xy_t               y_sh;
  z_t                step;

  assign x_sh = x >>> iter;
  assign y_sh = y >>> iter;
  assign step = atan_lut(iter);
  assign last = busy && (iter == ITER_W'(ITERS - 1));

  // NOTE: non-blocking assignments so x and y both update from the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      iter <= '0;
      busy <= 1'b0;
    end else if (load) begin
      x    <= x0;
      y    <= '0;
      z    <= z0;
      iter <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (!z[Z_W-1]) begin
        x <= x - y_sh;
        y <= y + x_sh;
        z <= z - step;
      end else begin
        x <= x + y_sh;
        y <= y - x_sh;
        z <= z + step;
      end
      iter <= iter + 1'b1;
      if (last) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/boreal_cordic_fk.sv
// 2-link planar forward kinematics: one time-shared CORDIC rotates L1 by theta_1,
// then L2 by theta_1+theta_2; the two vectors are summed, rounded and saturated.
module boreal_cordic_fk
  import boreal_kin_pkg::*;
#(
  parameter int L1 = L1_DEF,
  parameter int L2 = L2_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [THETA_W-1:0] theta_1,
  input  logic signed [THETA_W-1:0] theta_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [POS_W-1:0]   pos_x,
  output logic signed [POS_W-1:0]   pos_y
);

  localparam xy_t X0_L1 = start_mag(L1);
  localparam xy_t X0_L2 = start_mag(L2);

  fk_state_e state, state_nxt;
  z_t        theta1_r, sum_r;
  logic      primed;
  xy_t       acc_x, acc_y;

  z_t   t1_ext, t2_ext, t1_clamp, sum_raw, sum_wrap;
  z_t   pass_z, core_z0;
  xy_t  pass_mag, core_x0;
  xy_t  core_x, core_y;
  logic core_load, core_last;
  sum_t sum_x, sum_y;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    t1_ext   = {{(Z_W-THETA_W){theta_1[THETA_W-1]}}, theta_1};
    t2_ext   = {{(Z_W-THETA_W){theta_2[THETA_W-1]}}, theta_2};
    t1_clamp = t1_ext;
    if (t1_ext > PI)       t1_clamp = PI;
    else if (t1_ext < -PI) t1_clamp = -PI;
    sum_raw  = t1_clamp + t2_ext;
    sum_wrap = sum_raw;
    if (sum_raw > PI)       sum_wrap = sum_raw - TWO_PI;
    else if (sum_raw < -PI) sum_wrap = sum_raw + TWO_PI;
  end

  // Fold into [-pi/2, pi/2] so the CORDIC convergence range covers every angle.
  always_comb begin
    pass_z   = (state == ST_LOAD2) ? sum_r : theta1_r;
    pass_mag = (state == ST_LOAD2) ? X0_L2 : X0_L1;
    core_x0  = pass_mag;
    core_z0  = pass_z;
    if (pass_z > HALF_PI) begin
      core_x0 = -pass_mag;
      core_z0 = pass_z - PI;
    end else if (pass_z < -HALF_PI) begin
      core_x0 = -pass_mag;
      core_z0 = pass_z + PI;
    end
  end

  // Pass 1 loads on the first ITER1 cycle from the registered angle; pass 2 loads in LOAD2.
  assign core_load = ((state == ST_ITER1) && primed) || (state == ST_LOAD2);

  boreal_cordic_rotate u_rotate (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .x0    (core_x0),
    .z0    (core_z0),
    .x     (core_x),
    .y     (core_y),
    .last  (core_last)
  );

  assign sum_x    = (sum_t'(acc_x) + sum_t'(core_x) + sum_t'(1 << (FRAC_W - 1))) >>> FRAC_W;
  assign sum_y    = (sum_t'(acc_y) + sum_t'(core_y) + sum_t'(1 << (FRAC_W - 1))) >>> FRAC_W;
  assign in_ready = (state == ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid)  state_nxt = ST_ITER1;
      ST_ITER1: if (core_last) state_nxt = ST_LOAD2;
      ST_LOAD2:                state_nxt = ST_ITER2;
      ST_ITER2: if (core_last) state_nxt = ST_SUM;
      ST_SUM:                  state_nxt = ST_HOLD;
      ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
      default:                 state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      theta1_r  <= '0;
      sum_r     <= '0;
      primed    <= 1'b0;
      acc_x     <= '0;
      acc_y     <= '0;
      pos_x     <= '0;
      pos_y     <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (in_valid) begin
          theta1_r <= t1_clamp;
          sum_r    <= sum_wrap;
          primed   <= 1'b1;
        end
        ST_ITER1: primed <= 1'b0;
        ST_LOAD2: begin
          acc_x <= core_x;
          acc_y <= core_y;
        end
        ST_SUM: begin
          pos_x     <= sat_pos(sum_x);
          pos_y     <= sat_pos(sum_y);
          out_valid <= 1'b1;
        end
        ST_HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
